sram_port_arb: RTL and testbench

// Shares one single-port, 1-cycle-latency SRAM between the IF instruction port and the EX data port of the
// 5-stage core. Grants at most one access per cycle, routes read data back to its owner one cycle later,
// and raises stallreq to CTRL for the loser. Sits between mycpu_core's inst/data sram buses and the memory.

---
 rtl/sram_port_arb_pkg.sv | 28 ++
 rtl/sram_port_arb.sv | 93 +++++++++
 tb/tb_sram_port_arb.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arb_pkg.sv
// Shared types for the single-port SRAM arbiter: grant and response-owner
// encodings plus the helper that maps a grant to the response it produces.
package sram_port_arb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_NONE = 2'b00,
    ARB_INST = 2'b01,
    ARB_DATA = 2'b10
  } arb_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_INST = 2'b01,
    RESP_DATA = 2'b10
  } resp_e;

  // Writes return nothing, so only instruction fetches and data loads own a response slot.
  function automatic resp_e resp_of(input arb_e gnt, input logic [3:0] wen);
    case (gnt)
      ARB_INST: return RESP_INST;
      ARB_DATA: return (wen == 4'b0000) ? RESP_DATA : RESP_NONE;
      default:  return RESP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sram_port_arb.sv
// Arbitrates the IF instruction port and EX data port onto one 1-cycle-latency
// SRAM; returns read data to its owner a cycle later and stalls the loser.
module sram_port_arb
  import sram_port_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_rvalid,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_rvalid,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stallreq
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  resp_e            owner_q;
  logic             flush_pend;
  arb_e             gnt;
  logic             gnt_inst;
  logic             gnt_data;

  // Data normally wins; a fetch denied STARVE_MAX cycles in a row is forced through.
  always_comb begin
    // NOTE: default first so every path assigns gnt and no latch is inferred.
    gnt = ARB_NONE;
    if (inst_req && (!data_req || starve_cnt == STARVE_LIM)) gnt = ARB_INST;
    else if (data_req)                                       gnt = ARB_DATA;
  end

  assign gnt_inst = (gnt == ARB_INST);
  assign gnt_data = (gnt == ARB_DATA);

  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    case (gnt)
      ARB_INST: begin
        mem_en   = 1'b1;
        mem_addr = inst_addr;
      end
      ARB_DATA: begin
        mem_en    = 1'b1;
        mem_wen   = data_wen;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end
      default: ;
    endcase
  end

  assign stallreq = (inst_req & ~gnt_inst) | (data_req & ~gnt_data);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
    if (!rst) begin
      starve_cnt <= '0;
      owner_q    <= RESP_NONE;
      flush_pend <= 1'b0;
    end else begin
      if (!inst_req || gnt_inst)       starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + CNT_W'(1);
      owner_q    <= resp_of(gnt, data_wen);
      flush_pend <= flush & gnt_inst;
    end
  end

  // Gating with rst blanks any response still registered while reset is asserted.
  assign inst_rvalid = rst & (owner_q == RESP_INST) & ~flush_pend & ~flush;
  assign data_rvalid = rst & (owner_q == RESP_DATA);
  assign inst_rdata  = inst_rvalid ? mem_rdata : '0;
  assign data_rdata  = data_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_port_arb.sv
// Self-checking bench for sram_port_arb: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_sram_port_arb;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_rvalid;
  logic              data_req;
  logic [3:0]        data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_rvalid;
  logic              mem_en;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stallreq;

  sram_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_rvalid(inst_rvalid),
    .data_req   (data_req),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_rvalid(data_rvalid),
    .mem_en     (mem_en),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stallreq   (stallreq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: who gets the read data next cycle, how long inst has waited.
  int m_owner = 0;  // 0 none, 1 inst, 2 data
  int m_wait  = 0;
  bit m_fpend = 1'b0;
  bit m_gi;
  bit m_gd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Settle combinational outputs for the current inputs and compare with the model.
  task automatic eval();
    bit irv;
    bit drv;
    #1;
    m_gi = inst_req && (!data_req || m_wait >= STARVE_MAX);
    m_gd = data_req && !m_gi;
    irv  = rst && m_owner == 1 && !m_fpend && !flush;
    drv  = rst && m_owner == 2;
    check("mem_en",      mem_en,      m_gi || m_gd);
    check("mem_wen",     mem_wen,     m_gd ? data_wen : 4'b0000);
    check("mem_addr",    mem_addr,    m_gi ? inst_addr : (m_gd ? data_addr : '0));
    check("mem_wdata",   mem_wdata,   m_gd ? data_wdata : '0);
    check("stallreq",    stallreq,    (inst_req && !m_gi) || (data_req && !m_gd));
    check("inst_rvalid", inst_rvalid, irv);
    check("data_rvalid", data_rvalid, drv);
    check("inst_rdata",  inst_rdata,  irv ? mem_rdata : '0);
    check("data_rdata",  data_rdata,  drv ? mem_rdata : '0);
  endtask

  // Clock edge: advance the model, then return to the negedge to drive the next cycle.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_owner = 0;
      m_wait  = 0;
      m_fpend = 1'b0;
    end else begin
      m_wait  = (inst_req && !m_gi) ? ((m_wait + 1 > STARVE_MAX) ? STARVE_MAX : m_wait + 1) : 0;
      m_owner = m_gi ? 1 : ((m_gd && data_wen == 4'b0000) ? 2 : 0);
      m_fpend = flush && m_gi;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    inst_req = 1'b0;
    data_req = 1'b0;
    data_wen = 4'b0000;
    flush    = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    idle();
    inst_addr  = '0;
    data_addr  = '0;
    data_wdata = '0;
    mem_rdata  = '0;
    @(negedge clk);

    // Reset with both requests high: grant visible, no responses.
    inst_req  = 1'b1;
    data_req  = 1'b1;
    inst_addr = 32'h1000_0000;
    data_addr = 32'h2000_0000;
    for (int i = 0; i < 2; i++) begin
      eval();
      check("rst_inst_rvalid", inst_rvalid, 1'b0);
      tick();
    end
    rst = 1'b1;
    idle();
    eval();
    check("post_rst_rvalid", {inst_rvalid, data_rvalid}, 2'b00);
    tick();

    // Fetch only.
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0000;
    eval();
    check("fetch_addr", mem_addr, 32'hBFC0_0000);
    tick();
    idle();
    mem_rdata = 32'h2408_0001;
    eval();
    check("fetch_rvalid", inst_rvalid, 1'b1);
    check("fetch_rdata",  inst_rdata,  32'h2408_0001);
    check("fetch_stall",  stallreq,    1'b0);
    tick();

    // Both request, data load wins; inst follows once data drops.
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0004;
    data_req  = 1'b1;
    data_addr = 32'h8000_0010;
    eval();
    check("both_addr",  mem_addr, 32'h8000_0010);
    check("both_stall", stallreq, 1'b1);
    tick();
    data_req  = 1'b0;
    mem_rdata = 32'hCAFE_0010;
    eval();
    check("load_rvalid", data_rvalid, 1'b1);
    check("load_rdata",  data_rdata,  32'hCAFE_0010);
    check("inst_follow", mem_addr,    32'hBFC0_0004);
    tick();
    idle();
    mem_rdata = 32'h0000_1234;
    eval();
    check("inst_follow_rvalid", inst_rvalid, 1'b1);
    tick();

    // Starvation: data held 6 cycles, inst forced through on the 5th.
    inst_req  = 1'b1;
    data_req  = 1'b1;
    inst_addr = 32'hBFC0_0100;
    data_addr = 32'h8000_0200;
    for (int i = 1; i <= 6; i++) begin
      eval();
      check($sformatf("starve_c%0d", i), mem_addr, (i == 5) ? 32'hBFC0_0100 : 32'h8000_0200);
      tick();
    end
    idle();
    eval();
    tick();

    // Byte write: enables pass through, no response.
    data_req   = 1'b1;
    data_wen   = 4'b0011;
    data_addr  = 32'h8000_0300;
    data_wdata = 32'hDEAD_BEEF;
    eval();
    check("wr_wen",   mem_wen,   4'b0011);
    check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    idle();
    eval();
    check("wr_no_rvalid", data_rvalid, 1'b0);
    tick();

    // Flush in the response cycle.
    inst_req = 1'b1;
    eval();
    tick();
    idle();
    flush = 1'b1;
    eval();
    check("flush_resp_cycle", inst_rvalid, 1'b0);
    tick();

    // Flush in the grant cycle.
    inst_req = 1'b1;
    flush    = 1'b1;
    eval();
    tick();
    idle();
    eval();
    check("flush_grant_cycle", inst_rvalid, 1'b0);
    tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 31) != 0);
      flush      = ($urandom_range(0, 7) == 0);
      inst_req   = ($urandom_range(0, 3) != 0);
      data_req   = ($urandom_range(0, 2) != 0);
      data_wen   = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom_range(1, 15));
      inst_addr  = $urandom;
      data_addr  = $urandom;
      data_wdata = $urandom;
      mem_rdata  = $urandom;
      eval();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
